// File: rtl/speaker_tone_arbiter_pkg.sv
// Shared definitions for the speaker tone arbiter.
//  - state_e          : arbiter FSM states
//  - AMP_DEFAULT      : default positive square-wave amplitude
//  - GAP_CYC_DEFAULT  : default number of silent cycles after each tone
//  - neg16()          : 16-bit two's-complement negation
package speaker_tone_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [15:0] AMP_DEFAULT     = 16'h4000;
    localparam logic [15:0] GAP_CYC_DEFAULT = 16'd1000;

    function automatic logic [15:0] neg16(input logic [15:0] v);
        return (~v) + 16'd1;
    endfunction

endpackage

// File: rtl/speaker_tone_arbiter_tone_gen.sv
// Square-wave tone generator.
//  clk, rst_n : clock, asynchronous active-low reset
//  load       : start a new tone with half-period div (div=0 means rest)
//  div        : half-period in clk cycles
//  en         : advance the tone by one cycle (high while the tone keeps playing)
//  sample     : registered 16-bit sample, +AMP / -AMP / 0
module tone_gen
    import speaker_tone_arbiter_pkg::*;
#(
    parameter int          DIV_W = 20,
    parameter logic [15:0] AMP   = AMP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    input  logic             en,
    output logic [15:0]      sample
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [15:0]      sample_q, sample_d;

    always_comb begin
        div_d    = div_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        sample_d = 16'd0;
        if (load) begin
            // First sample of the tone is already on the output in the ack cycle.
            div_d    = div;
            cnt_d    = (div == '0) ? '0 : div - DIV_W'(1);
            phase_d  = 1'b0;
            sample_d = (div == '0) ? 16'd0 : AMP;
        end else if (en) begin
            if (div_q != '0) begin
                if (cnt_q == '0) begin
                    cnt_d   = div_q - DIV_W'(1);
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
                sample_d = phase_d ? neg16(AMP) : AMP;
            end
        end else begin
            // Tone over: silence and park the counter.
            cnt_d   = '0;
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            sample_q <= 16'd0;
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
        end
    end

    assign sample = sample_q;

endmodule

// File: rtl/speaker_tone_arbiter.sv
// Fixed-priority arbiter sharing the speaker among N_REQ tone requesters.
//  clk, rst_n   : clock, asynchronous active-low reset
//  req          : per-requester request, held until ack
//  div_in       : per-requester half-period, slice i = [i*DIV_W +: DIV_W]
//  dur_in       : per-requester duration,    slice i = [i*DUR_W +: DUR_W]
//  ack / done   : 1-cycle pulses on accept / tone finished
//  busy         : high in PLAY and GAP
//  grant_id     : active requester, valid while busy
//  audio_left/right : identical registered 16-bit samples
module speaker_tone_arbiter
    import speaker_tone_arbiter_pkg::*;
#(
    parameter int          N_REQ   = 3,
    parameter int          DIV_W   = 20,
    parameter int          DUR_W   = 24,
    parameter logic [15:0] AMP     = AMP_DEFAULT,
    parameter logic [15:0] GAP_CYC = GAP_CYC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DIV_W-1:0] div_in,
    input  logic [N_REQ*DUR_W-1:0] dur_in,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [1:0]             grant_id,
    output logic [15:0]            audio_left,
    output logic [15:0]            audio_right
);

    state_e             state_q, state_d;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic [15:0]        gap_cnt_q, gap_cnt_d;
    logic [1:0]         grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;

    logic [DIV_W-1:0]   div_arr [N_REQ];
    logic [DUR_W-1:0]   dur_arr [N_REQ];

    logic               req_any;
    logic [1:0]         req_idx;
    logic [DIV_W-1:0]   sel_div;
    logic [DUR_W-1:0]   sel_dur;

    logic               tone_load;
    logic               tone_en;
    logic [DIV_W-1:0]   tone_div;
    logic [15:0]        sample;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign div_arr[gi] = div_in[gi*DIV_W +: DIV_W];
            assign dur_arr[gi] = dur_in[gi*DUR_W +: DUR_W];
        end
    endgenerate

    // Priority encoder: scan from the top so the lowest set index wins.
    always_comb begin
        req_any = |req;
        req_idx = 2'd0;
        sel_div = '0;
        sel_dur = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                req_idx = 2'(i);
                sel_div = div_arr[i];
                sel_dur = dur_arr[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        dur_cnt_d = dur_cnt_q;
        gap_cnt_d = gap_cnt_q;
        grant_d   = grant_q;
        ack_d     = '0;
        done_d    = '0;
        tone_load = 1'b0;
        tone_en   = 1'b0;
        // A zero-length tone is loaded as a rest so it never makes a sound.
        tone_div  = (sel_dur == '0) ? '0 : sel_div;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    grant_d   = req_idx;
                    dur_cnt_d = sel_dur;
                    tone_load = 1'b1;
                    state_d   = ST_PLAY;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (req_idx == 2'(i)) ack_d[i] = 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                // dur_cnt holds cycles left including this one; dur=0 and dur=1
                // both leave after the single ack cycle.
                if (dur_cnt_q <= DUR_W'(1)) begin
                    dur_cnt_d = '0;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (grant_q == 2'(i)) done_d[i] = 1'b1;
                    end
                    if (GAP_CYC == 16'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = GAP_CYC - 16'd1;
                        state_d   = ST_GAP;
                    end
                end else begin
                    dur_cnt_d = dur_cnt_q - DUR_W'(1);
                    tone_en   = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dur_cnt_q <= '0;
            gap_cnt_q <= 16'd0;
            grant_q   <= 2'd0;
            ack_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dur_cnt_q <= dur_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    tone_gen #(
        .DIV_W (DIV_W),
        .AMP   (AMP)
    ) u_tone_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tone_load),
        .div    (tone_div),
        .en     (tone_en),
        .sample (sample)
    );

    assign ack         = ack_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign audio_left  = sample;
    assign audio_right = sample;

endmodule

// File: tb/tb_speaker_tone_arbiter.sv
module tb_speaker_tone_arbiter;

    localparam int          N_REQ   = 3;
    localparam int          DIV_W   = 20;
    localparam int          DUR_W   = 24;
    localparam logic [15:0] GAP_CYC = 16'd3;
    localparam logic [15:0] POS     = 16'h4000;
    localparam logic [15:0] NEG     = 16'hC000;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*DIV_W-1:0] div_in;
    logic [N_REQ*DUR_W-1:0] dur_in;
    logic [N_REQ-1:0]       ack;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [1:0]             grant_id;
    logic [15:0]            audio_left;
    logic [15:0]            audio_right;

    speaker_tone_arbiter #(
        .N_REQ   (N_REQ),
        .DIV_W   (DIV_W),
        .DUR_W   (DUR_W),
        .AMP     (16'h4000),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .div_in      (div_in),
        .dur_in      (dur_in),
        .ack         (ack),
        .done        (done),
        .busy        (busy),
        .grant_id    (grant_id),
        .audio_left  (audio_left),
        .audio_right (audio_right)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_REQ-1:0] ack;
        logic [N_REQ-1:0] done;
        logic             busy;
        logic [1:0]       grant;
        logic [15:0]      audio;
    } exp_t;

    typedef struct {
        int id;
        int div;
        int dur;
    } tone_vec_t;

    exp_t      sb_q[$];
    tone_vec_t vecs[6];
    int        n_tests = 0;
    int        n_fail  = 0;

    function automatic logic [15:0] exp_sample(input int div, input int dur, input int k);
        if (dur == 0 || div == 0) return 16'h0000;
        return (((k - 1) / div) % 2 == 1) ? NEG : POS;
    endfunction

    function automatic exp_t mk(input logic [N_REQ-1:0] a, input logic [N_REQ-1:0] d,
                                input logic b, input int g, input logic [15:0] au);
        exp_t e;
        e.ack   = a;
        e.done  = d;
        e.busy  = b;
        e.grant = 2'(g);
        e.audio = au;
        return e;
    endfunction

    // Expected cycles from the ack cycle through the done cycle.
    task automatic push_tone(input int id, input int div, input int dur);
        int len;
        logic [N_REQ-1:0] one;
        one = N_REQ'(1) << id;
        len = (dur == 0) ? 1 : dur;
        for (int k = 1; k <= len; k++)
            sb_q.push_back(mk((k == 1) ? one : '0, '0, 1'b1, id, exp_sample(div, dur, k)));
        sb_q.push_back(mk('0, one, 1'b1, id, 16'h0000));
    endtask

    // Remaining silent GAP cycles after the done cycle, then one IDLE cycle.
    task automatic push_gap(input int id);
        for (int k = 1; k < int'(GAP_CYC); k++)
            sb_q.push_back(mk('0, '0, 1'b1, id, 16'h0000));
        sb_q.push_back(mk('0, '0, 1'b0, 0, 16'h0000));
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++)
            sb_q.push_back(mk('0, '0, 1'b0, 0, 16'h0000));
    endtask

    task automatic set_params(input int id, input int div, input int dur);
        div_in[id*DIV_W +: DIV_W] = DIV_W'(div);
        dur_in[id*DUR_W +: DUR_W] = DUR_W'(dur);
    endtask

    // Pop one expected record and compare it with the DUT one cycle later.
    task automatic check_rec(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        @(posedge clk);
        #1;
        n_tests++;
        if (ack !== e.ack || done !== e.done || busy !== e.busy ||
            (e.busy && grant_id !== e.grant) ||
            audio_left !== e.audio || audio_right !== e.audio) begin
            n_fail++;
            $display("FAIL %s @%0t: got ack=%b done=%b busy=%b grant=%0d L=%h R=%h, expected ack=%b done=%b busy=%b grant=%0d audio=%h",
                     tag, $time, ack, done, busy, grant_id, audio_left, audio_right,
                     e.ack, e.done, e.busy, e.grant, e.audio);
        end
        // Requester behaviour: drop the request once it has been acknowledged.
        if (e.ack != '0) req = req & ~e.ack;
    endtask

    task automatic check_stream(input string tag);
        while (sb_q.size() > 0) check_rec(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 200000", $time);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 4, 20};
        vecs[1] = '{2, 0, 10};
        vecs[2] = '{0, 5, 0};
        vecs[3] = '{0, 1, 6};
        vecs[4] = '{2, 3, 7};
        vecs[5] = '{1, 2, 1};

        rst_n  = 1'b0;
        req    = 3'b111;
        div_in = '0;
        dur_in = '0;
        set_params(0, 2, 5);
        set_params(1, 3, 4);
        set_params(2, 1, 3);

        // Reset held with all requests high: everything stays quiet.
        push_idle(3);
        check_stream("reset_hold");
        n_tests++;
        if (grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_grant: got %0d, expected 0", grant_id);
        end
        $display("[TB] reset hold checked");

        // Release: priority order 0,1,2 with the others pending each time.
        @(negedge clk);
        rst_n = 1'b1;
        push_tone(0, 2, 5); push_gap(0);
        push_tone(1, 3, 4); push_gap(1);
        push_tone(2, 1, 3); push_gap(2);
        check_stream("release_prio");
        $display("[TB] release with req=111 served ids 0,1,2 in order");

        // Table of single tones.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            set_params(vecs[v].id, vecs[v].div, vecs[v].dur);
            req[vecs[v].id] = 1'b1;
            push_tone(vecs[v].id, vecs[v].div, vecs[v].dur);
            push_gap(vecs[v].id);
            check_stream($sformatf("tone_vec%0d", v));
            $display("[TB] tone id=%0d div=%0d dur=%0d checked", vecs[v].id, vecs[v].div, vecs[v].dur);
        end

        // Contention: 0 and 2 together; 2 waits through the gap.
        @(negedge clk);
        set_params(0, 4, 6);
        set_params(2, 2, 5);
        req = 3'b101;
        push_tone(0, 4, 6); push_gap(0);
        push_tone(2, 2, 5); push_gap(2);
        check_stream("contention");
        $display("[TB] contention req=101 checked");

        // Request dropped before the sampling edge: no grant.
        @(negedge clk);
        req = 3'b100;
        #2;
        req = 3'b000;
        push_idle(3);
        check_stream("drop_before_ack");
        $display("[TB] dropped request checked");

        // Reset during PLAY cycle 5 of 20, request still high afterwards.
        @(negedge clk);
        set_params(1, 4, 20);
        req[1] = 1'b1;
        push_tone(1, 4, 20);
        for (int k = 0; k < 5; k++) check_rec("mid_reset_play");
        sb_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || audio_left !== 16'h0000 || audio_right !== 16'h0000 || done !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b L=%h R=%h done=%b, expected busy=0 audio=0000 done=000",
                     busy, audio_left, audio_right, done);
        end
        req[1] = 1'b1;
        push_idle(2);
        check_stream("mid_reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        push_tone(1, 4, 20); push_gap(1);
        check_stream("regrant_after_reset");
        $display("[TB] reset mid-tone and re-grant checked");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
